// File: rtl/fpu_addsub_pipe.sv
// fpu_addsub_pipe: registered issue/writeback wrapper around the combinational
// Addition_Subtraction unit. S1 holds one operand pair and drives the unit.
// S2 is a 2-entry result queue that carries {result, exc, tag}. Exceptions are
// tracked with a sticky flag and a saturating counter.
//
// Handshake on both sides: a transfer occurs on a rising CLK edge where valid
// and ready are both high. A producer holds valid and payload stable until that
// edge. ready may depend combinationally on the downstream ready.
module fpu_addsub_pipe #(
  parameter int TAG_W     = 4,
  parameter int EXC_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_a,
  input  logic [31:0]          in_b,
  input  logic                 in_sub,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_result,
  output logic                 out_exc,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 exc_sticky,
  output logic [EXC_CNT_W-1:0] exc_count,
  input  logic                 exc_clear
);

  typedef struct packed {
    logic [31:0]      result;
    logic             exc;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic             s1_valid;
  logic [31:0]      s1_a;
  logic [31:0]      s1_b;
  logic             s1_sub;
  logic [TAG_W-1:0] s1_tag;

  logic [31:0]      au_result;
  logic             au_exc;

  entry_t           q_head;
  entry_t           q_tail;
  entry_t           s1_entry;
  logic [1:0]       q_count;

  logic             q_pop;
  logic             q_free;
  logic             s1_advance;
  logic             accept;

  Addition_Subtraction u_addsub (
    .a_operand  (s1_a),
    .b_operand  (s1_b),
    .AddBar_Sub (s1_sub),
    .Exception  (au_exc),
    .result     (au_result)
  );

  // Per-cycle handshake decisions. The queue head drives the out_* ports directly.
  always_comb begin
    out_valid  = (q_count != 2'd0);
    q_pop      = out_valid & out_ready;
    q_free     = (q_count != 2'd2) | q_pop;
    s1_advance = s1_valid & q_free;
    in_ready   = ~s1_valid | s1_advance;
    accept     = in_valid & in_ready;
    s1_entry   = {au_result, au_exc, s1_tag};
    out_result = q_head.result;
    out_exc    = q_head.exc;
    out_tag    = q_head.tag;
  end

  // S1 operand register. It reloads in the same cycle it advances, so there is no bubble.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sub   <= 1'b0;
      s1_tag   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_sub   <= in_sub;
      s1_tag   <= in_tag;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Two-entry queue. The head is always q_head, and a pop shifts q_tail forward.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      q_head  <= '0;
      q_tail  <= '0;
      q_count <= 2'd0;
    end else begin
      case ({s1_advance, q_pop})
        2'b10: begin
          if (q_count == 2'd0) q_head <= s1_entry;
          else                 q_tail <= s1_entry;
          q_count <= q_count + 2'd1;
        end
        2'b01: begin
          q_head  <= q_tail;
          q_count <= q_count - 2'd1;
        end
        2'b11: begin
          if (q_count == 2'd1) begin
            q_head <= s1_entry;
          end else begin
            q_head <= q_tail;
            q_tail <= s1_entry;
          end
        end
        default: ;
      endcase
    end
  end

  // Exception tracking. A clear wins over an exception in the same cycle, and the counter saturates.
  always_ff @(posedge CLK) begin
    if (RESET || exc_clear) begin
      exc_sticky <= 1'b0;
      exc_count  <= '0;
    end else if (s1_advance && au_exc) begin
      exc_sticky <= 1'b1;
      if (exc_count != {EXC_CNT_W{1'b1}}) exc_count <= exc_count + 1'b1;
    end
  end

endmodule

// Addition_Subtraction: combinational single-precision add/subtract.
// Rounding is by truncation. Results that underflow flush to zero.
// Any Inf/NaN operand raises Exception and forces the result to 0.
module Addition_Subtraction (
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        AddBar_Sub,
  output logic        Exception,
  output logic [31:0] result
);

  logic        swap;
  logic [30:0] mag_x;
  logic [30:0] mag_y;
  logic        eff_sub;
  logic        res_sign;
  logic [7:0]  exp_x;
  logic [7:0]  exp_y;
  logic [7:0]  shift;
  logic [7:0]  res_exp;
  logic [23:0] sig_x;
  logic [23:0] sig_y;
  logic [23:0] sig_y_al;
  logic [24:0] sum;
  logic [4:0]  lead;
  logic [4:0]  lsh;
  logic [22:0] res_man;
  logic        flush;

  // Order operands by magnitude, align, add or subtract, then normalise.
  always_comb begin
    swap     = (a_operand[30:0] < b_operand[30:0]);
    mag_x    = swap ? b_operand[30:0] : a_operand[30:0];
    mag_y    = swap ? a_operand[30:0] : b_operand[30:0];
    eff_sub  = a_operand[31] ^ b_operand[31] ^ AddBar_Sub;
    res_sign = swap ? (b_operand[31] ^ AddBar_Sub) : a_operand[31];
    exp_x    = (mag_x[30:23] == 8'd0) ? 8'd1 : mag_x[30:23];
    exp_y    = (mag_y[30:23] == 8'd0) ? 8'd1 : mag_y[30:23];
    sig_x    = {(mag_x[30:23] != 8'd0), mag_x[22:0]};
    sig_y    = {(mag_y[30:23] != 8'd0), mag_y[22:0]};
    shift    = exp_x - exp_y;
    sig_y_al = (shift > 8'd24) ? 24'd0 : (sig_y >> shift);
    sum      = eff_sub ? ({1'b0, sig_x} - {1'b0, sig_y_al})
                       : ({1'b0, sig_x} + {1'b0, sig_y_al});
    lead = 5'd0;
    for (int i = 0; i < 25; i++) begin
      if (sum[i]) lead = i[4:0];
    end
    lsh     = 5'd0;
    res_exp = exp_x;
    res_man = sum[22:0];
    flush   = (sum == 25'd0);
    if (sum[24]) begin
      res_man = sum[23:1];
      res_exp = exp_x + 8'd1;
    end else if (!flush) begin
      lsh     = 5'd23 - lead;
      res_man = sum[22:0] << lsh;
      if ({3'b000, lsh} >= exp_x) flush = 1'b1;
      else                        res_exp = exp_x - {3'b000, lsh};
    end
    Exception = (&a_operand[30:23]) | (&b_operand[30:23]);
    if (Exception || flush) result = 32'd0;
    else                    result = {res_sign, res_exp, res_man};
  end

endmodule
